modular_exponentiation: RTL and testbench
=========================================

# modular_exponentiation

Computes A_result = x^exponent mod modulus for 512-bit odd moduli with left-to-right binary square-and-multiply over Montgomery multiplication (R = 2^512). The host supplies the precomputed constants R mod m and R² mod m. It is the top-level arithmetic engine of the RSA datapath. It sits below the host interface and owns a single Montgomery multiplier instance.

## Interface
- No parameters; operand width fixed at 512.
- clk  in  1  single clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-high (asserted = 1 clears all state; the port keeps the codebase name despite the polarity).
- startExponentiation  in  1  level request; sampled only in IDLE.
- x  in  512  base, x < modulus.
- modulus  in  512  odd modulus m, m < 2^512.
- exponent  in  512  exponent e, unsigned.
- Rmodm  in  512  2^512 mod m.
- Rsquaredmodm  in  512  2^1024 mod m.
- done  out  1  completion flag; reset 0.
- A_result  out  512  result register; reset 0.

## Operation
- MM(a,b) = a·b·2^-512 mod m, with the output fully reduced (< m).
- On accepted start, latch x, modulus, exponent, Rmodm and Rsquaredmodm into internal registers. Inputs may change afterwards.
- Compute xt = MM(x, Rsquaredmodm) and set A = Rmodm.
- Scan the exponent from bit 511 down to bit 0:
  - Always compute A = MM(A,A).
  - If the bit is 1, also compute A = MM(A, xt).
- Leading zero bits are processed, not skipped. This is harmless because MM(Rmodm, Rmodm) = Rmodm.
- Finally compute A = MM(A, 1), write A into A_result and assert done.
- exponent = 0 gives 1 (for m > 1).
- FSM states:
  - IDLE: on start → LOAD.
  - LOAD: 1 cycle; latch inputs, bit index = 511 → PRE.
  - PRE: wait for xt → SQUARE.
  - SQUARE: wait for square; if e[i] = 1 → MULT, else → NEXT.
  - MULT: wait for multiply → NEXT.
  - NEXT: if i = 0 → POST; else decrement i → SQUARE.
  - POST: wait for final MM → DONE; A_result is written on this transition.
  - DONE: done = 1; stay while startExponentiation = 1; when it is 0 → IDLE.
- startExponentiation outside IDLE is ignored. A held-high start therefore cannot retrigger until it has been seen low.
- A_result holds its value until the next POST completion. It keeps its value through IDLE and across a new start.

## Timing
- Reset, in any state: FSM → IDLE, done = 0, A_result = 0, multiplier aborted. A run interrupted by reset is lost and needs a fresh start after release.
- Multiplier latency Lmm: fixed at 514 cycles from its start pulse to its done pulse (bit-serial radix-2 with final conditional subtract).
- Total latency from the start-sampling edge to done high is 1 + (2 + 512 + popcount(e))·(Lmm + 1) + 1 cycles, data-independent apart from popcount.
- done rises in the same cycle that A_result becomes valid.
- done stays high for at least 1 cycle, and for as long as start remains high.

## Structure
- Sub-module montgomery_mul:
  - Ports: clk, resetn, start, a[511:0], b[511:0], m[511:0], done, result[511:0].
  - Radix-2 with a 514-bit accumulator and final subtraction.
  - One instance, multiplexed by the FSM between the (x, R²), (A, A), (A, xt) and (A, 1) operand pairs.
- Shared package: WIDTH = 512, the state enum, and the constant ONE = 512'd1.

## Test plan
- Vector 1:
  - x = 87b21d93a10f35511c8d56264a6f95f0245d8004e0d3557c7ec2b396b4ed3cabda34f88e0c8154e9ffab2761e626a720eef1da7ee31ce6c31fcdeaec38eb9589
  - e = af
  - m = d97a21880ab3b85681ef6162732ffcd3cf303982004568f7fba23d0d411ced4080fd567efcd793b308936f7522ead3c53ad80440edd50088935d2a3d9b9c5885
  - Rmodm = 2685de77f54c47a97e109e9d8cd0032c30cfc67dffba9708045dc2f2bee312bf7f02a98103286c4cf76c908add152c3ac527fbbf122aff776ca2d5c26463a77b
  - Rsquaredmodm = 733f6233b70f1ff7bc7ea9a38d69c2d083bec7c1d73000a3c36a6b4699300aff43a2c4da76786ac6878e16ad896b861ad351008baa901886630148792eca57ad
  - → A_result = bdb2a4a461dbff5011756139d13f5446a7eb6c9979b55e8fa687b6edaa842d502fc159a825fe144175f9b5616000e5c971e67f150f5135dd5d6fd220f7400189.
- m = 2^512−1, Rmodm = 1, Rsquaredmodm = 1, x = 3, e = 5 → 243 (0xf3); also e = 0 → 1.
- m = 2^512−3, Rmodm = 3, Rsquaredmodm = 9, x = 2, e = 10 → 1024; also e = 1 → 2.
- start held high after done → exactly one run, done stays 1, A_result stable; drop start, raise it again → second run, same result.
- resetn pulsed mid-SQUARE → done = 0 and A_result = 0 immediately; a fresh start then yields the correct vector-1 result.
- Inputs changed one cycle after start is accepted → result unchanged.

Source files
------------

// File: rtl/modular_exponentiation_pkg.sv
// modular_exponentiation_pkg: shared width, FSM state and multiplier operand-select types
package modular_exponentiation_pkg;
    localparam int WIDTH = 512;
    localparam logic [WIDTH-1:0] ONE = 512'd1;
    typedef enum logic [2:0] {IDLE, LOAD, PRE, SQUARE, MULT, NEXT, POST, DONE} state_t;
    typedef enum logic [1:0] {OP_XT, OP_SQ, OP_MUL, OP_FIN} op_t;
endpackage

// File: rtl/modular_exponentiation_montgomery_mul.sv
// montgomery_mul: bit-serial radix-2 Montgomery product a*b*2^-512 mod m, 514 cycles start-to-done
module montgomery_mul
    import modular_exponentiation_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] a_sh, b_r, m_r;
    logic [WIDTH+1:0] acc, t, u;
    logic [9:0] cnt;
    logic busy;
    // acc stays below 2m, so acc + b + m < 4m fits in WIDTH+2 bits
    always_comb begin
        t = acc + (a_sh[0] ? {2'b00, b_r} : '0);
        u = t + (t[0] ? {2'b00, m_r} : '0);
    end
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            a_sh   <= '0;
            b_r    <= '0;
            m_r    <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_sh <= a;
                b_r  <= b;
                m_r  <= m;
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (cnt == 10'd512) begin
                    result <= WIDTH'((acc >= {2'b00, m_r}) ? acc - {2'b00, m_r} : acc);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end else begin
                    acc  <= u >> 1;
                    a_sh <= a_sh >> 1;
                    cnt  <= cnt + 10'd1;
                end
            end
        end
    end
endmodule

// File: rtl/modular_exponentiation.sv
// modular_exponentiation: left-to-right square-and-multiply x^e mod m over one Montgomery multiplier
module modular_exponentiation
    import modular_exponentiation_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             startExponentiation,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] Rmodm,
    input  logic [WIDTH-1:0] Rsquaredmodm,
    output logic             done,
    output logic [WIDTH-1:0] A_result
);
    state_t state;
    op_t op, next_op;
    logic [WIDTH-1:0] x_r, m_r, e_r, rr_r, xt, acc_a, mm_a, mm_b, mm_res;
    logic [8:0] idx;
    logic issued, mm_start, mm_done;
    always_comb begin
        next_op = (idx == '0) ? OP_FIN : OP_SQ;
        mm_a = (op == OP_XT) ? x_r : acc_a;
        mm_b = (op == OP_XT) ? rr_r : (op == OP_SQ) ? acc_a : (op == OP_MUL) ? xt : ONE;
    end
    montgomery_mul u_mm (
        .clk    (clk),
        .resetn (resetn),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .m      (m_r),
        .done   (mm_done),
        .result (mm_res)
    );
    // Each completing product launches the next one on the same edge, so ops chain back to back
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state    <= IDLE;
            op       <= OP_XT;
            issued   <= 1'b0;
            mm_start <= 1'b0;
            idx      <= '0;
            x_r      <= '0;
            m_r      <= '0;
            e_r      <= '0;
            rr_r     <= '0;
            xt       <= '0;
            acc_a    <= '0;
            done     <= 1'b0;
            A_result <= '0;
        end else begin
            mm_start <= 1'b0;
            case (state)
                IDLE: if (startExponentiation) begin
                    x_r   <= x;
                    m_r   <= modulus;
                    e_r   <= exponent;
                    rr_r  <= Rsquaredmodm;
                    acc_a <= Rmodm;
                    state <= LOAD;
                end
                LOAD: begin
                    issued <= 1'b0;
                    idx    <= 9'd511;
                    state  <= PRE;
                end
                PRE: if (!issued) begin
                    issued   <= 1'b1;
                    mm_start <= 1'b1;
                    op       <= OP_XT;
                end else if (mm_done) begin
                    xt       <= mm_res;
                    mm_start <= 1'b1;
                    op       <= OP_SQ;
                    state    <= SQUARE;
                end
                SQUARE: if (mm_done) begin
                    acc_a    <= mm_res;
                    mm_start <= 1'b1;
                    op       <= e_r[idx] ? OP_MUL : next_op;
                    state    <= e_r[idx] ? MULT : NEXT;
                end
                MULT: if (mm_done) begin
                    acc_a    <= mm_res;
                    mm_start <= 1'b1;
                    op       <= next_op;
                    state    <= NEXT;
                end
                NEXT: begin
                    state <= (idx == '0) ? POST : SQUARE;
                    if (idx != '0) idx <= idx - 9'd1;
                end
                POST: if (mm_done) begin
                    A_result <= mm_res;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: if (!startExponentiation) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modular_exponentiation.sv
// tb_modular_exponentiation: directed runs with an expected-result queue and immediate assertions
module tb_modular_exponentiation;
    localparam int W = 512;
    localparam int LMM = 514;
    localparam logic [W-1:0] V1_X  = 512'h87b21d93a10f35511c8d56264a6f95f0245d8004e0d3557c7ec2b396b4ed3cabda34f88e0c8154e9ffab2761e626a720eef1da7ee31ce6c31fcdeaec38eb9589;
    localparam logic [W-1:0] V1_E  = 512'haf;
    localparam logic [W-1:0] V1_M  = 512'hd97a21880ab3b85681ef6162732ffcd3cf303982004568f7fba23d0d411ced4080fd567efcd793b308936f7522ead3c53ad80440edd50088935d2a3d9b9c5885;
    localparam logic [W-1:0] V1_R  = 512'h2685de77f54c47a97e109e9d8cd0032c30cfc67dffba9708045dc2f2bee312bf7f02a98103286c4cf76c908add152c3ac527fbbf122aff776ca2d5c26463a77b;
    localparam logic [W-1:0] V1_R2 = 512'h733f6233b70f1ff7bc7ea9a38d69c2d083bec7c1d73000a3c36a6b4699300aff43a2c4da76786ac6878e16ad896b861ad351008baa901886630148792eca57ad;
    localparam logic [W-1:0] V1_A  = 512'hbdb2a4a461dbff5011756139d13f5446a7eb6c9979b55e8fa687b6edaa842d502fc159a825fe144175f9b5616000e5c971e67f150f5135dd5d6fd220f7400189;
    localparam logic [W-1:0] M_ALL1 = {W{1'b1}};
    localparam logic [W-1:0] M_FD   = {{(W-8){1'b1}}, 8'hfd};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic [W-1:0] x = '0, modulus = '0, exponent = '0, rmodm = '0, rsq = '0;
    logic done;
    logic [W-1:0] a_result;
    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    modular_exponentiation dut (
        .clk                 (clk),
        .resetn              (resetn),
        .startExponentiation (start),
        .x                   (x),
        .modulus             (modulus),
        .exponent            (exponent),
        .Rmodm               (rmodm),
        .Rsquaredmodm        (rsq),
        .done                (done),
        .A_result            (a_result)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Leaves start high and returns 1ns after the accepting edge
    task automatic launch(input logic [W-1:0] bx, bm, be, br, br2, ex);
        repeat (2) @(negedge clk);
        x = bx;
        modulus = bm;
        exponent = be;
        rmodm = br;
        rsq = br2;
        start = 1'b1;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
    endtask

    task automatic finish_run(input string tag, input int pc);
        int cnt = 0;
        logic [W-1:0] ev;
        while (!done && cnt < 300000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_latency"}, W'(cnt), W'(2 + (LMM + 1) * (514 + pc)));
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_result"}, a_result, ev);
    endtask

    initial begin
        #2 resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", W'(done), '0);
        chk("reset_result", a_result, '0);
        @(negedge clk);
        resetn = 1'b0;

        launch(512'd3, M_ALL1, 512'd5, 512'd1, 512'd1, 512'hf3);
        start = 1'b0;
        finish_run("m1_e5", 2);
        launch(512'd3, M_ALL1, 512'd0, 512'd1, 512'd1, 512'd1);
        start = 1'b0;
        finish_run("m1_e0", 0);
        launch(512'd2, M_FD, 512'd10, 512'd3, 512'd9, 512'd1024);
        start = 1'b0;
        finish_run("m3_e10", 2);
        launch(512'd2, M_FD, 512'd1, 512'd3, 512'd9, 512'd2);
        start = 1'b0;
        finish_run("m3_e1", 1);

        launch(V1_X, V1_M, V1_E, V1_R, V1_R2, V1_A);
        x = '1;
        modulus = '0;
        exponent = '1;
        rmodm = '0;
        rsq = '0;
        finish_run("v1_held", 6);
        repeat (600) @(posedge clk);
        #1;
        chk("held_done", W'(done), W'(1));
        chk("held_result", a_result, V1_A);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_done", W'(done), '0);
        chk("idle_result", a_result, V1_A);
        launch(V1_X, V1_M, V1_E, V1_R, V1_R2, V1_A);
        start = 1'b0;
        finish_run("v1_again", 6);

        launch(V1_X, V1_M, V1_E, V1_R, V1_R2, V1_A);
        start = 1'b0;
        repeat (800) @(posedge clk);
        #3 resetn = 1'b1;
        #1;
        chk("midrun_reset_done", W'(done), '0);
        chk("midrun_reset_result", a_result, '0);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b0;
        launch(V1_X, V1_M, V1_E, V1_R, V1_R2, V1_A);
        start = 1'b0;
        finish_run("v1_after_reset", 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
